mux2to1: RTL and testbench

Clocked 2:1 selector that forwards one of two data words to a registered output under a select line. It is the basic steering element of the datapath, used wherever two sources share one destination register. An optional bypass mode lets the same block act as a purely combinational mux. It has one clock and an asynchronous active-low reset.

---
 rtl/mux2to1_if.sv | 21 ++
 rtl/mux2to1.sv | 44 ++++
 tb/tb_mux2to1.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mux2to1_if.sv
// Steering-mux bus: capture enable, select, two data sources and the selected result.
interface mux2to1_if #(
  parameter int WIDTH = 1
);
  logic             en;
  logic             SEL;
  logic [WIDTH-1:0] D0;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] OUT;
  logic             out_valid;

  modport master (
    output en, SEL, D0, D1,
    input  OUT, out_valid
  );

  modport slave (
    input  en, SEL, D0, D1,
    output OUT, out_valid
  );
endinterface

// File: rtl/mux2to1.sv
// 2:1 steering mux: one-cycle registered capture gated by en, or zero-latency combinational bypass.
// No backpressure; with en low the registered output holds indefinitely.
module mux2to1 #(
  parameter int          WIDTH      = 1,
  parameter int          REGISTERED = 1,
  parameter logic [63:0] RESET_VAL  = 64'd0
) (
  input logic       clk,
  input logic       rst_n,
  mux2to1_if.slave  bus
);

  localparam logic [WIDTH-1:0] LP_RESET_VAL = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] w_sel_dat;

  // ?: keeps agreeing bits resolved when SEL is unknown
  assign w_sel_dat = bus.SEL ? bus.D1 : bus.D0;

  if (REGISTERED != 0) begin : g_reg
    logic [WIDTH-1:0] r_out;
    logic             r_out_vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out     <= LP_RESET_VAL;
        r_out_vld <= 1'b0;
      end else if (bus.en) begin
        r_out     <= w_sel_dat;
        r_out_vld <= 1'b1;
      end
    end

    assign bus.OUT       = r_out;
    assign bus.out_valid = r_out_vld;
  end else begin : g_comb
    logic w_unused;

    assign w_unused      = &{1'b0, clk, bus.en};
    assign bus.OUT       = rst_n ? w_sel_dat : LP_RESET_VAL;
    assign bus.out_valid = rst_n;
  end

endmodule

// File: tb/tb_mux2to1.sv
// Directed bench: registered WIDTH=1, combinational WIDTH=8, registered WIDTH=8 with RESET_VAL=FF.
module tb_mux2to1;

  logic clk;
  logic clk_stop;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mux2to1_if #(.WIDTH(1)) if_a ();
  mux2to1_if #(.WIDTH(8)) if_b ();
  mux2to1_if #(.WIDTH(8)) if_c ();

  mux2to1 #(.WIDTH(1), .REGISTERED(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  mux2to1 #(.WIDTH(8), .REGISTERED(0)) u_b (
    .clk   (clk_stop),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  mux2to1 #(.WIDTH(8), .REGISTERED(1), .RESET_VAL(64'hFF)) u_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic d0s [5];
    logic d1s [5];

    d0s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    d1s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    n_tests  = 0;
    n_fail   = 0;
    clk_stop = 1'b0;
    rst_n    = 1'b0;

    if_a.en = 1'b1; if_a.SEL = 1'b1; if_a.D0 = 1'b1;  if_a.D1 = 1'b1;
    if_b.en = 1'b1; if_b.SEL = 1'b0; if_b.D0 = 8'hA5; if_b.D1 = 8'h3C;
    if_c.en = 1'b1; if_c.SEL = 1'b1; if_c.D0 = 8'h11; if_c.D1 = 8'h22;

    // reset held across several edges with capture conditions present
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_a_out", 64'(if_a.OUT), 64'd0);
      chk("rst_a_vld", 64'(if_a.out_valid), 64'd0);
      chk("rst_c_out", 64'(if_c.OUT), 64'hFF);
      chk("rst_c_vld", 64'(if_c.out_valid), 64'd0);
    end
    chk("rst_b_out", 64'(if_b.OUT), 64'd0);
    chk("rst_b_vld", 64'(if_b.out_valid), 64'd0);

    #2 rst_n = 1'b1;
    #1;
    chk("rel_a_out_before_edge", 64'(if_a.OUT), 64'd0);
    chk("rel_c_out_before_edge", 64'(if_c.OUT), 64'hFF);

    // SEL=0 sweep
    if_a.SEL = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if_a.D0 = d0s[i];
      if_a.D1 = d1s[i];
      tick();
      chk($sformatf("sel0_out_%0d", i), 64'(if_a.OUT), 64'(d0s[i]));
      chk($sformatf("sel0_vld_%0d", i), 64'(if_a.out_valid), 64'd1);
    end

    // SEL=1 sweep
    if_a.SEL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if_a.D0 = d0s[i];
      if_a.D1 = d1s[i];
      tick();
      chk($sformatf("sel1_out_%0d", i), 64'(if_a.OUT), 64'(d1s[i]));
    end

    // inputs changing between edges stay invisible
    if_a.SEL = 1'b0;
    if_a.D0  = 1'b1;
    #2;
    chk("between_edges", 64'(if_a.OUT), 64'd0);
    tick();
    chk("after_edge", 64'(if_a.OUT), 64'd1);

    // enable hold
    if_a.SEL = 1'b1; if_a.D0 = 1'b0; if_a.D1 = 1'b1;
    tick();
    chk("hold_capture", 64'(if_a.OUT), 64'd1);
    if_a.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if_a.SEL = ~if_a.SEL;
      if_a.D0  = ~if_a.D0;
      if_a.D1  = ~if_a.D1;
      tick();
      chk($sformatf("hold_out_%0d", i), 64'(if_a.OUT), 64'd1);
    end
    if_a.en = 1'b1; if_a.SEL = 1'b0; if_a.D0 = 1'b0;
    tick();
    chk("reenable_out", 64'(if_a.OUT), 64'd0);

    // combinational instance, its clock never toggles
    if_b.SEL = 1'b0;
    #1;
    chk("comb_sel0", 64'(if_b.OUT), 64'hA5);
    chk("comb_vld", 64'(if_b.out_valid), 64'd1);
    if_b.SEL = 1'b1;
    #1;
    chk("comb_sel1", 64'(if_b.OUT), 64'h3C);
    if_b.en = 1'b0; if_b.SEL = 1'b0;
    #1;
    chk("comb_en_ignored", 64'(if_b.OUT), 64'hA5);

    // WIDTH=8, RESET_VAL=FF instance
    if_c.SEL = 1'b1; if_c.D1 = 8'h00;
    tick();
    chk("w8_d1_zero", 64'(if_c.OUT), 64'h00);
    chk("w8_vld", 64'(if_c.out_valid), 64'd1);
    if_c.SEL = 1'b0; if_c.D0 = 8'hC3;
    tick();
    chk("w8_d0", 64'(if_c.OUT), 64'hC3);
    if_c.SEL = 1'bx; if_c.D0 = 8'h5A; if_c.D1 = 8'h5A;
    tick();
    chk("w8_selx_same", 64'(if_c.OUT), 64'h5A);

    // asynchronous reset mid-cycle after a capture
    if_a.en = 1'b1; if_a.SEL = 1'b1; if_a.D1 = 1'b1;
    tick();
    chk("pre_async_a", 64'(if_a.OUT), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_a_out", 64'(if_a.OUT), 64'd0);
    chk("async_a_vld", 64'(if_a.out_valid), 64'd0);
    chk("async_c_out", 64'(if_c.OUT), 64'hFF);
    chk("async_b_out", 64'(if_b.OUT), 64'd0);
    chk("async_b_vld", 64'(if_b.out_valid), 64'd0);
    tick();
    chk("rst_edge_a_out", 64'(if_a.OUT), 64'd0);
    chk("rst_edge_c_vld", 64'(if_c.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
